// File: rtl/range_mon_pkg.sv
// Shared types and helpers for the range monitor.
// Holds the FSM state enum and the extended-width compare helper.
package range_mon_pkg;

    typedef enum logic {
        ARMED   = 1'b0,
        TRIPPED = 1'b1
    } mon_state_t;

    // Operands are pre-extended to MAX_W bits: sign-extended in signed
    // mode, zero-extended otherwise. A signed compare at MAX_W is then
    // correct for both modes as long as WIDTH < MAX_W.
    localparam int MAX_W = 64;

    function automatic logic val_lt(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b
    );
        return $signed(a) < $signed(b);
    endfunction

endpackage

// File: rtl/range_mon_chan.sv
// One monitored channel: bounds compare, config check, persistence count.
// Ports: smpl/lo_lim/hi_lim in, ch_en/smpl_vld/clr in; hit, hi_dir, cfg_err out.
module range_mon_chan
    import range_mon_pkg::*;
#(
    parameter int WIDTH   = 20,
    parameter int SIGNED  = 0,
    parameter int PERSIST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             smpl_vld,
    input  logic             clr,
    input  logic             ch_en,
    input  logic [WIDTH-1:0] smpl,
    input  logic [WIDTH-1:0] lo_lim,
    input  logic [WIDTH-1:0] hi_lim,
    output logic             hit,
    output logic             hi_dir,
    output logic             cfg_err
);

    localparam int CNT_W = $clog2(PERSIST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERSIST);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             cfg_err_d, cfg_err_q;
    logic             below, above, active;
    logic [MAX_W-1:0] s_x, lo_x, hi_x;

    function automatic logic [MAX_W-1:0] ext(input logic [WIDTH-1:0] v);
        if (SIGNED != 0)
            return {{(MAX_W-WIDTH){v[WIDTH-1]}}, v};
        else
            return {{(MAX_W-WIDTH){1'b0}}, v};
    endfunction

    always_comb begin
        s_x       = ext(smpl);
        lo_x      = ext(lo_lim);
        hi_x      = ext(hi_lim);
        below     = val_lt(s_x, lo_x);
        above     = val_lt(hi_x, s_x);
        cfg_err_d = val_lt(hi_x, lo_x);
        active    = ch_en && !cfg_err_q;
        cnt_d     = cnt_q;
        hit       = 1'b0;
        if (clr || !active) begin
            cnt_d = '0;
        end else if (smpl_vld) begin
            if (below || above) begin
                // Reaching or already sitting at the limit both count as a hit.
                if (cnt_q >= CNT_MAX - CNT_W'(1)) begin
                    cnt_d = CNT_MAX;
                    hit   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign hi_dir  = above;
    assign cfg_err = cfg_err_q;

endmodule

// File: rtl/range_monitor.sv
// Multi-channel bounds monitor with persistence, sticky faults, first-fault capture.
// Ports: smpl/lo_lim/hi_lim/ch_en/smpl_vld/clr in; fault, trip, first_*, cfg_err out.
module range_monitor
    import range_mon_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int WIDTH   = 20,
    parameter int SIGNED  = 0,
    parameter int PERSIST = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    smpl_vld,
    input  logic [NUM_CH*WIDTH-1:0] smpl,
    input  logic [NUM_CH*WIDTH-1:0] lo_lim,
    input  logic [NUM_CH*WIDTH-1:0] hi_lim,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    clr,
    output logic [NUM_CH-1:0]       fault,
    output logic                    fault_any,
    output logic                    trip,
    output logic [CH_W-1:0]         first_ch,
    output logic [WIDTH-1:0]        first_val,
    output logic                    first_hi,
    output logic [NUM_CH-1:0]       cfg_err
);

    logic [NUM_CH-1:0] hit, hi_dir;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        range_mon_chan #(
            .WIDTH  (WIDTH),
            .SIGNED (SIGNED),
            .PERSIST(PERSIST)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .smpl_vld(smpl_vld),
            .clr     (clr),
            .ch_en   (ch_en[i]),
            .smpl    (smpl[i*WIDTH +: WIDTH]),
            .lo_lim  (lo_lim[i*WIDTH +: WIDTH]),
            .hi_lim  (hi_lim[i*WIDTH +: WIDTH]),
            .hit     (hit[i]),
            .hi_dir  (hi_dir[i]),
            .cfg_err (cfg_err[i])
        );
    end

    mon_state_t        state_d, state_q;
    logic [NUM_CH-1:0] fault_d, fault_q;
    logic              trip_d, trip_q;
    logic [CH_W-1:0]   first_ch_d, first_ch_q;
    logic [WIDTH-1:0]  first_val_d, first_val_q;
    logic              first_hi_d, first_hi_q;
    logic [CH_W-1:0]   enc_ch;
    logic [WIDTH-1:0]  enc_val;
    logic              enc_hi;

    // Lowest-index hitting channel wins: scan downward, last match sticks.
    always_comb begin
        enc_ch  = '0;
        enc_val = '0;
        enc_hi  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                enc_ch  = CH_W'(i);
                enc_val = smpl[i*WIDTH +: WIDTH];
                enc_hi  = hi_dir[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        trip_d      = 1'b0;
        first_ch_d  = first_ch_q;
        first_val_d = first_val_q;
        first_hi_d  = first_hi_q;
        if (clr) begin
            state_d     = ARMED;
            fault_d     = '0;
            first_ch_d  = '0;
            first_val_d = '0;
            first_hi_d  = 1'b0;
        end else begin
            fault_d = fault_q | hit;
            unique case (state_q)
                ARMED: begin
                    if (|hit) begin
                        state_d     = TRIPPED;
                        trip_d      = 1'b1;
                        first_ch_d  = enc_ch;
                        first_val_d = enc_val;
                        first_hi_d  = enc_hi;
                    end
                end
                TRIPPED: ;
                default: state_d = ARMED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARMED;
            fault_q     <= '0;
            trip_q      <= 1'b0;
            first_ch_q  <= '0;
            first_val_q <= '0;
            first_hi_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fault_q     <= fault_d;
            trip_q      <= trip_d;
            first_ch_q  <= first_ch_d;
            first_val_q <= first_val_d;
            first_hi_q  <= first_hi_d;
        end
    end

    assign fault     = fault_q;
    assign fault_any = |fault_q;
    assign trip      = trip_q;
    assign first_ch  = first_ch_q;
    assign first_val = first_val_q;
    assign first_hi  = first_hi_q;

endmodule

// File: tb/tb_range_monitor.sv
// Directed bench for range_monitor: unsigned 2-channel and signed 1-channel.
// Drives inputs 1 time unit after each rising edge and checks there too.
module tb_range_monitor;
    import range_mon_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // Unsigned instance: NUM_CH=2, WIDTH=20, PERSIST=4
    logic        vld, clr;
    logic [39:0] smpl, lo, hi;
    logic [1:0]  ch_en;
    logic [1:0]  fault, cfg_err;
    logic        fault_any, trip, first_ch, first_hi;
    logic [19:0] first_val;

    // Signed instance: NUM_CH=1, WIDTH=13, PERSIST=4
    logic        s_vld, s_clr;
    logic [12:0] s_smpl, s_lo, s_hi;
    logic [0:0]  s_ch_en, s_fault, s_cfg_err;
    logic        s_fault_any, s_trip, s_first_ch, s_first_hi;
    logic [12:0] s_first_val;

    int n_cmp = 0;
    int n_err = 0;

    range_monitor #(.NUM_CH(2), .WIDTH(20), .SIGNED(0), .PERSIST(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .smpl_vld(vld), .smpl(smpl),
        .lo_lim(lo), .hi_lim(hi), .ch_en(ch_en), .clr(clr),
        .fault(fault), .fault_any(fault_any), .trip(trip),
        .first_ch(first_ch), .first_val(first_val), .first_hi(first_hi),
        .cfg_err(cfg_err)
    );

    range_monitor #(.NUM_CH(1), .WIDTH(13), .SIGNED(1), .PERSIST(4)) u_sdut (
        .clk(clk), .rst_n(rst_n), .smpl_vld(s_vld), .smpl(s_smpl),
        .lo_lim(s_lo), .hi_lim(s_hi), .ch_en(s_ch_en), .clr(s_clr),
        .fault(s_fault), .fault_any(s_fault_any), .trip(s_trip),
        .first_ch(s_first_ch), .first_val(s_first_val), .first_hi(s_first_hi),
        .cfg_err(s_cfg_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_pulse();
        vld = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        vld = 0; clr = 0; ch_en = 2'b11;
        smpl = {20'd1000, 20'd1000};
        lo   = {20'd100, 20'd100};
        hi   = {20'd50000, 20'd50000};
        s_vld = 0; s_clr = 0; s_ch_en = 1'b1;
        s_smpl = 13'd0; s_lo = -13'sd1000; s_hi = 13'sd1000;

        // Reset state
        step(); step();
        chk("rst_fault", fault, 0);
        chk("rst_fault_any", fault_any, 0);
        chk("rst_trip", trip, 0);
        chk("rst_first_ch", first_ch, 0);
        chk("rst_first_val", first_val, 0);
        chk("rst_first_hi", first_hi, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        step();

        // Unsigned trip on ch0 above hi
        smpl[19:0] = 20'd50001; vld = 1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("utrip_pre_trip", trip, 0);
            chk("utrip_pre_fault", fault, 0);
        end
        step();
        chk("utrip_fault", fault, 2'b01);
        chk("utrip_fault_any", fault_any, 1);
        chk("utrip_trip", trip, 1);
        chk("utrip_first_ch", first_ch, 0);
        chk("utrip_first_val", first_val, 50001);
        chk("utrip_first_hi", first_hi, 1);
        vld = 0;
        step();
        chk("utrip_pulse_end", trip, 0);
        chk("utrip_hold_val", first_val, 50001);
        clr_pulse();
        step();
        chk("clr_fault", fault, 0);
        chk("clr_first_val", first_val, 0);

        // 3 bad / 1 good / 3 bad never trips
        vld = 1;
        for (int k = 0; k < 7; k++) begin
            smpl[19:0] = (k == 3) ? 20'd1000 : 20'd50001;
            step();
            chk("p313_trip", trip, 0);
        end
        chk("p313_fault", fault, 0);
        smpl[19:0] = 20'd1000;
        step();
        vld = 0;

        // Simultaneous hit, ch1 below lo
        smpl = {20'd50, 20'd50001}; vld = 1;
        step(); step(); step(); step();
        chk("simul_fault", fault, 2'b11);
        chk("simul_trip", trip, 1);
        chk("simul_first_ch", first_ch, 0);
        chk("simul_first_val", first_val, 50001);
        clr_pulse();

        // Post-trip activity: ch1 first, then ch0
        smpl = {20'd60000, 20'd1000}; vld = 1;
        step(); step(); step(); step();
        chk("post_trip1", trip, 1);
        chk("post_first_ch", first_ch, 1);
        chk("post_first_val", first_val, 60000);
        chk("post_fault1", fault, 2'b10);
        smpl[19:0] = 20'd20;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_no_second_trip", trip, 0);
        end
        chk("post_fault2", fault, 2'b11);
        chk("post_first_ch_held", first_ch, 1);
        chk("post_first_hi_held", first_hi, 1);
        clr_pulse();
        step();
        chk("post_clr_fault", fault, 0);
        // Back in ARMED: a fresh trip must pulse again
        smpl[19:0] = 20'd1000; vld = 1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("rearm_trip", trip, (k == 4) ? 1 : 0);
        end
        chk("rearm_first_ch", first_ch, 1);
        clr_pulse();
        smpl = {20'd1000, 20'd1000}; vld = 1;
        step();

        // clr in the same cycle as the 4th bad sample
        smpl[19:0] = 20'd50001;
        step(); step(); step();
        clr = 1;
        step();
        clr = 0;
        chk("clrprio_fault", fault, 0);
        chk("clrprio_trip", trip, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("clrprio_recount", trip, (k == 4) ? 1 : 0);
        end
        clr_pulse();

        // Sparse smpl_vld with 5-cycle gaps
        for (int k = 1; k <= 4; k++) begin
            vld = 1;
            step();
            chk("gap_trip", trip, (k == 4) ? 1 : 0);
            vld = 0;
            if (k < 4) begin
                for (int g = 0; g < 5; g++) step();
                chk("gap_fault", fault, 0);
            end
        end
        chk("gap_fault_end", fault, 2'b01);
        clr_pulse();

        // Disabled channel never trips
        ch_en = 2'b10; vld = 1;
        for (int k = 0; k < 6; k++) step();
        chk("dis_fault", fault, 0);
        ch_en = 2'b11; vld = 0;
        smpl[19:0] = 20'd1000; vld = 1;
        step();
        vld = 0;

        // Inverted limits: cfg_err and no trip
        lo[19:0] = 20'd600; hi[19:0] = 20'd500;
        smpl[19:0] = 20'd50001; vld = 1;
        step();
        chk("cfg_err_set", cfg_err, 2'b01);
        for (int k = 0; k < 6; k++) step();
        chk("cfg_no_fault", fault, 0);
        chk("cfg_no_trip", trip, 0);
        vld = 0;
        lo[19:0] = 20'd100; hi[19:0] = 20'd50000;
        step();
        chk("cfg_err_clear", cfg_err, 0);

        // Reset while TRIPPED
        vld = 1;
        step(); step(); step(); step();
        chk("rstmid_pre_fault", fault, 2'b01);
        rst_n = 0; clr = 1;
        step();
        rst_n = 1; clr = 0; vld = 0;
        chk("rstmid_fault", fault, 0);
        chk("rstmid_fault_any", fault_any, 0);
        chk("rstmid_trip", trip, 0);
        chk("rstmid_first_val", first_val, 0);
        chk("rstmid_first_hi", first_hi, 0);
        step();

        // Signed: -1001 x4 trips below lo
        s_smpl = -13'sd1001; s_vld = 1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("s_trip", s_trip, (k == 4) ? 1 : 0);
        end
        chk("s_fault", s_fault, 1);
        chk("s_first_hi", s_first_hi, 0);
        chk("s_first_val", s_first_val, 13'h1c17);
        s_vld = 0; s_clr = 1;
        step();
        s_clr = 0; s_vld = 1;
        // Exact limits are in bounds
        for (int k = 0; k < 8; k++) begin
            s_smpl = k[0] ? 13'sd1000 : -13'sd1000;
            step();
        end
        chk("s_edge_fault", s_fault, 0);
        chk("s_edge_cfg", s_cfg_err, 0);
        s_smpl = 13'sd1001;
        for (int k = 0; k < 4; k++) step();
        chk("s_hi_first_hi", s_first_hi, 1);
        s_vld = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
